sel_scan_mux: RTL and testbench
===============================

SEL_SCAN_MUX -- requirements
Module: sel_scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning data bits per channel (1..32).
REQ-002 SHALL have parameter CHANNELS, default 8, meaning number of input channels (2..64).
REQ-003 SHALL have derived localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports exactly as follows:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- d  input  CHANNELS*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  direct-mode channel select.
- en_bar  input  1  active-low enable.
- mode  input  1  0 = direct select, 1 = auto-scan.
- scan_start  input  1  single-cycle pulse that starts a scan.
- y  output  WIDTH  registered selected data.
- w  output  WIDTH  registered bitwise complement of y.
- ch_out  output  SEL_W  channel presented on y.
- valid  output  1  y holds a legal channel sample.
- scan_done  output  1  one-cycle pulse after the last channel is sampled.

Function
REQ-005 SHALL keep y, w, ch_out, valid and scan_done fully registered, with 1-cycle latency from inputs to outputs.
REQ-006 SHALL hold w == ~y at every cycle, including during reset.
REQ-007 Direct mode (mode=0), en_bar=0, sel<CHANNELS: next cycle y=d[sel], ch_out=sel, valid=1.
REQ-008 Direct mode, sel>=CHANNELS: next cycle y=0, ch_out=sel, valid=0.
REQ-009 en_bar=1 in any state: next cycle y=0, valid=0; ch_out holds.
REQ-010 FSM states: IDLE, SCAN, DONE.
REQ-011 IDLE->SCAN on scan_start=1, mode=1, en_bar=0; the internal channel counter loads 0.
REQ-012 In SCAN with en_bar=0: each cycle y=d[cnt], ch_out=cnt, valid=1, and cnt increments.
REQ-013 In SCAN with en_bar=1: pause; cnt holds, valid=0, y=0; resume at the held cnt when en_bar returns to 0.
REQ-014 SCAN->DONE after the cycle that samples cnt=CHANNELS-1.
REQ-015 DONE SHALL assert scan_done for exactly one cycle, then return to IDLE.
REQ-016 scan_start while in SCAN or DONE SHALL be ignored.
REQ-017 mode=0 while in SCAN SHALL abort to IDLE the next cycle, with no scan_done, and direct-mode behaviour resumes.
REQ-018 In IDLE with mode=1 and no scan in progress: y=0, valid=0.
REQ-019 cnt SHALL never exceed CHANNELS-1 when CHANNELS is not a power of two.

Reset
REQ-020 While rst_n=0: y=0, w=all ones, ch_out=0, valid=0, scan_done=0, state=IDLE, cnt=0.
REQ-021 rst_n asserted mid-scan SHALL abort the scan immediately with no scan_done; a new scan_start is required after release.

Configuration
REQ-022 Macro SEL_SCAN_MUX_CONT_SCAN_EN defined: after cnt=CHANNELS-1, cnt wraps to 0 and SCAN continues. scan_done pulses in the cycle after each pass completes, and valid stays continuous. Only mode=0, en_bar handling (REQ-013) or reset end the scan.
REQ-023 Macro undefined: single-pass behaviour per REQ-014/015.

Structure
REQ-024 Package sel_scan_mux_pkg SHALL hold the FSM state typedef (IDLE/SCAN/DONE) and the MODE_DIRECT/MODE_SCAN constants.
REQ-025 The channel counter SHALL be a sub-module sel_scan_ctr with load, increment, hold and wrap-at-CHANNELS-1 functions.

Verification
REQ-026 Reset: rst_n=0 with random d -> y=0, w=all ones, valid=0, scan_done=0.
REQ-027 Direct, WIDTH=8, CHANNELS=8, d[5]=0xA5, sel=5, en_bar=0 -> next cycle y=0xA5, w=0x5A, ch_out=5, valid=1; then en_bar=1 -> y=0, w=0xFF, valid=0.
REQ-028 CHANNELS=6, sel=7 -> y=0, valid=0; scan with d[k]=k -> y sequence 0..5 on 6 consecutive cycles, then scan_done=1 for one cycle.
REQ-029 Scan with en_bar=1 for 3 cycles at cnt=3 -> valid=0 for 3 cycles, then y resumes at d[3] with no channel skipped or repeated.
REQ-030 mode=0 at cnt=2 -> return to IDLE, no scan_done; scan_start during SCAN is ignored, so the pass length stays CHANNELS.
REQ-031 With SEL_SCAN_MUX_CONT_SCAN_EN: CHANNELS=4 -> y cycles 0,1,2,3,0,1,... with scan_done every 4th cycle; rst_n=0 mid-pass -> outputs reset immediately.

Source files
------------

// File: rtl/sel_scan_mux_pkg.sv
// Shared types and constants for the selectable/scanning channel mux.
// Optional build macro: SEL_SCAN_MUX_CONT_SCAN_EN (continuous scan), used by sel_scan_mux.
package sel_scan_mux_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  // Encoding of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Select width for a given channel count; never narrower than one bit.
  function automatic int unsigned calc_sel_w(input int unsigned channels);
    int unsigned w;
    w = $clog2(channels);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sel_scan_ctr.sv
// Scan channel counter: load-to-zero, increment, hold, and wrap after CHANNELS-1.
// Wrapping at CHANNELS-1 keeps the count legal for non-power-of-two channel counts.
module sel_scan_ctr #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [SEL_W-1:0] LastCnt = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over increment; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/sel_scan_mux.sv
// Channel mux with direct select and an auto-scan sequencer; all outputs registered.
// Build macro SEL_SCAN_MUX_CONT_SCAN_EN: when defined the scan wraps and runs continuously,
// pulsing scan_done after every pass; when undefined a scan is a single pass.
module sel_scan_mux
  import sel_scan_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 8,
  localparam int unsigned SEL_W   = calc_sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en_bar,
  input  logic                      mode,
  input  logic                      scan_start,
  output logic [WIDTH-1:0]          y,
  output logic [WIDTH-1:0]          w,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      valid,
  output logic                      scan_done
);

  scan_state_e state_q, state_d;

  logic [WIDTH-1:0] y_q, y_d, w_q;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             done_q;

  logic             ctr_load, ctr_inc;
  logic [SEL_W-1:0] cnt;
  logic             cnt_last;
  logic             sel_legal;

  // Channel slice lookup; an index outside 0..CHANNELS-1 yields zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] data,
                                            input logic [SEL_W-1:0]          idx);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        res = data[k*WIDTH +: WIDTH];
      end
    end
    return res;
  endfunction

  assign sel_legal = (32'(sel) < CHANNELS);

  sel_scan_ctr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_ctr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (ctr_load),
    .inc_i  (ctr_inc),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // Next-state and next-output decode for the sequencer and the direct path.
  always_comb begin
    state_d  = state_q;
    y_d      = '0;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((mode == MODE_SCAN) && scan_start && !en_bar) begin
          state_d  = StScan;
          ctr_load = 1'b1;
        end
      end
      StScan: begin
        if (mode == MODE_DIRECT) begin
          // Abort: no pass-complete marker, so no scan_done follows.
          state_d  = StIdle;
          ctr_load = 1'b1;
        end else if (!en_bar) begin
          y_d     = pick(d, cnt);
          ch_d    = cnt;
          valid_d = 1'b1;
          ctr_inc = 1'b1;
          if (cnt_last) begin
            wrap_d = 1'b1;
`ifdef SEL_SCAN_MUX_CONT_SCAN_EN
            state_d = StScan;
`else
            state_d = StDone;
`endif
          end
        end
        // en_bar high: pause with counter held and outputs blanked.
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Direct select applies whenever mode is direct, including the abort cycle.
    if ((mode == MODE_DIRECT) && !en_bar) begin
      ch_d = sel;
      if (sel_legal) begin
        y_d     = pick(d, sel);
        valid_d = 1'b1;
      end
    end
  end

  // State and output registers; w is registered from ~y_d so it tracks ~y every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      w_q     <= '1;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      w_q     <= ~y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      // wrap_q is set alongside the last sample, so done lands one cycle after it.
      done_q  <= wrap_q;
    end
  end

  assign y         = y_q;
  assign w         = w_q;
  assign ch_out    = ch_q;
  assign valid     = valid_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_sel_scan_mux.sv
// Directed bench for sel_scan_mux (WIDTH=8, CHANNELS=6); honours SEL_SCAN_MUX_CONT_SCAN_EN.
module tb_sel_scan_mux;

  localparam int unsigned W = 8;
  localparam int unsigned N = 6;
`ifdef SEL_SCAN_MUX_CONT_SCAN_EN
  localparam bit Cont = 1'b1;
`else
  localparam bit Cont = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N*W-1:0] d;
  logic [2:0]   sel;
  logic         en_bar;
  logic         mode;
  logic         scan_start;
  logic [W-1:0] y;
  logic [W-1:0] w;
  logic [2:0]   ch_out;
  logic         valid;
  logic         scan_done;

  int checks = 0;
  int errors = 0;

  sel_scan_mux #(
    .WIDTH    (W),
    .CHANNELS (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .sel        (sel),
    .en_bar     (en_bar),
    .mode       (mode),
    .scan_start (scan_start),
    .y          (y),
    .w          (w),
    .ch_out     (ch_out),
    .valid      (valid),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic [7:0] ey, input logic [2:0] ech,
                          input logic ev, input logic ed);
    logic [7:0] ew;
    ew = ~ey;
    chk({tag, ".y"}, {24'h0, y}, {24'h0, ey});
    chk({tag, ".w"}, {24'h0, w}, {24'h0, ew});
    chk({tag, ".ch"}, {29'h0, ch_out}, {29'h0, ech});
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, ev});
    chk({tag, ".done"}, {31'h0, scan_done}, {31'h0, ed});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    d[k*8 +: 8] = v;
  endtask

  initial begin
    d          = {$urandom, $urandom};
    sel        = 3'd5;
    en_bar     = 1'b0;
    mode       = 1'b0;
    scan_start = 1'b0;

    // Reset, asynchronous and held across edges
    #1 rst_n = 1'b0;
    #1 expect_o("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 expect_o("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Direct mode
    set_ch(5, 8'hA5);
    step(); expect_o("dir_sel5", 8'hA5, 3'd5, 1'b1, 1'b0);
    en_bar = 1'b1;
    step(); expect_o("dir_en_bar", 8'h00, 3'd5, 1'b0, 1'b0);
    en_bar = 1'b0; set_ch(2, 8'h3C); sel = 3'd2;
    step(); expect_o("dir_sel2", 8'h3C, 3'd2, 1'b1, 1'b0);
    sel = 3'd7;
    step(); expect_o("dir_sel7", 8'h00, 3'd7, 1'b0, 1'b0);
    sel = 3'd6;
    step(); expect_o("dir_sel6", 8'h00, 3'd6, 1'b0, 1'b0);

    // Full scan, with a stray scan_start mid-pass
    for (int k = 0; k < 6; k++) set_ch(k, 8'(k));
    mode = 1'b1; scan_start = 1'b1;
    step(); expect_o("scan_start", 8'h00, 3'd6, 1'b0, 1'b0);
    scan_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      scan_start = (k == 2);
      step(); expect_o($sformatf("scan_y%0d", k), 8'(k), 3'(k), 1'b1, 1'b0);
    end
    scan_start = 1'b0;
    step(); expect_o("scan_done", 8'h00, Cont ? 3'd0 : 3'd5, Cont, 1'b1);
    step(); expect_o("scan_after", Cont ? 8'h01 : 8'h00, Cont ? 3'd1 : 3'd5, Cont, 1'b0);
    mode = 1'b0; en_bar = 1'b1;
    step(); expect_o("idle", 8'h00, Cont ? 3'd1 : 3'd5, 1'b0, 1'b0);

    // Pause for three cycles at cnt=3
    en_bar = 1'b0; mode = 1'b1; scan_start = 1'b1;
    step(); expect_o("pause_start", 8'h00, Cont ? 3'd1 : 3'd5, 1'b0, 1'b0);
    scan_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); expect_o($sformatf("pause_y%0d", k), 8'(k), 3'(k), 1'b1, 1'b0);
    end
    en_bar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_o($sformatf("paused%0d", i), 8'h00, 3'd2, 1'b0, 1'b0);
    end
    en_bar = 1'b0;
    for (int k = 3; k < 6; k++) begin
      step(); expect_o($sformatf("resume_y%0d", k), 8'(k), 3'(k), 1'b1, 1'b0);
    end
    step(); expect_o("pause_done", 8'h00, Cont ? 3'd0 : 3'd5, Cont, 1'b1);
    mode = 1'b0; en_bar = 1'b1;
    step(); expect_o("pause_idle", 8'h00, Cont ? 3'd0 : 3'd5, 1'b0, 1'b0);

    // Abort with mode=0 at cnt=2
    en_bar = 1'b0; mode = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(); expect_o($sformatf("abort_y%0d", k), 8'(k), 3'(k), 1'b1, 1'b0);
    end
    mode = 1'b0; sel = 3'd1;
    step(); expect_o("abort", 8'h01, 3'd1, 1'b1, 1'b0);
    sel = 3'd4;
    step(); expect_o("abort_dir", 8'h04, 3'd4, 1'b1, 1'b0);
    step(); expect_o("abort_nodone", 8'h04, 3'd4, 1'b1, 1'b0);

    // Reset mid-scan
    mode = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); expect_o("mid_y0", 8'h00, 3'd0, 1'b1, 1'b0);
    step(); expect_o("mid_y1", 8'h01, 3'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 expect_o("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); expect_o("post_rst0", 8'h00, 3'd0, 1'b0, 1'b0);
    step(); expect_o("post_rst1", 8'h00, 3'd0, 1'b0, 1'b0);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); expect_o("rescan_y0", 8'h00, 3'd0, 1'b1, 1'b0);
    step(); expect_o("rescan_y1", 8'h01, 3'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
